unified_mem_arbiter: RTL and testbench

//  Shares one single-port, variable-latency memory between the IF stage (read-only fetch)
//  and the MEM stage (load/store) of the 5-stage pipelined CPU. Arbitrates the two

---
 rtl/unified_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_unified_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch and data access.
// The data side wins arbitration until fetch has been passed over STARVE_LIMIT times in a row.
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ready,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  m_req,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_ack,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  busy,
    output logic [2:0]            o_state
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    // Handshake: a requester holds req (and its address/data) until its ready pulse;
    // m_req is held until m_ack, and m_ack is only honoured while m_req is high.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GRANT_I = 3'd1,
        S_GRANT_D = 3'd2,
        S_RESP_I  = 3'd3,
        S_RESP_D  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_m_we;
    logic [ADDR_WIDTH-1:0] r_m_addr;
    logic [DATA_WIDTH-1:0] r_m_wdata;
    logic [DATA_WIDTH-1:0] r_i_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;
    logic                  w_starved;
    logic                  w_pick_i;
    logic                  w_pick_d;
    logic [CNT_W-1:0]      w_cnt_inc;

    assign w_starved = (r_cnt == CNT_W'(STARVE_LIMIT));
    assign w_pick_i  = i_req && (!d_req || w_starved);
    assign w_pick_d  = d_req && !w_pick_i;
    assign w_cnt_inc = w_starved ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pick_i) begin
                    w_next = S_GRANT_I;
                end else if (w_pick_d) begin
                    w_next = S_GRANT_D;
                end
            end
            S_GRANT_I: if (m_ack) w_next = S_RESP_I;
            S_GRANT_D: if (m_ack) w_next = S_RESP_D;
            S_RESP_I:  w_next = S_IDLE;
            S_RESP_D:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        m_req   = 1'b0;
        i_ready = 1'b0;
        d_ready = 1'b0;
        busy    = 1'b1;
        case (r_state)
            S_IDLE:    busy    = 1'b0;
            S_GRANT_I: m_req   = 1'b1;
            S_GRANT_D: m_req   = 1'b1;
            S_RESP_I:  i_ready = 1'b1;
            S_RESP_D:  d_ready = 1'b1;
            default:   busy    = 1'b0;
        endcase
    end

    // Request fields are captured once at grant and held for the whole transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                if (w_pick_i) begin
                    r_m_addr <= i_addr;
                    r_m_we   <= 1'b0;
                    r_cnt    <= '0;
                end else if (w_pick_d) begin
                    r_m_addr  <= d_addr;
                    r_m_we    <= d_we;
                    r_m_wdata <= d_wdata;
                    r_cnt     <= i_req ? w_cnt_inc : '0;
                end
            end
            if (r_state == S_GRANT_I && m_ack) begin
                r_i_rdata <= m_rdata;
            end
            if (r_state == S_GRANT_D && m_ack && !r_m_we) begin
                r_d_rdata <= m_rdata;
            end
        end
    end

    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign o_state = r_state;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: fetch, load, store, starvation order and reset abort,
// against a simple variable-latency memory model.
module tb_unified_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ready;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_ack;
    logic [DW-1:0] m_rdata;
    logic          busy;
    logic [2:0]    o_state;

    // clock / reset block
    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .STARVE_LIMIT(2)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy), .o_state(o_state)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // memory model: acks after ack_delay extra cycles of m_req; force_ack injects stray acks
    int            ack_delay = 0;
    int            wait_cnt = 0;
    logic          model_ack = 1'b0;
    logic          force_ack = 1'b0;
    logic [DW-1:0] rdata_val = '0;

    always @(negedge clk) begin
        if (m_req) begin
            if (wait_cnt >= ack_delay) begin
                model_ack = 1'b1;
                wait_cnt  = 0;
            end else begin
                model_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            model_ack = 1'b0;
            wait_cnt  = 0;
        end
    end

    assign m_ack   = model_ack | force_ack;
    assign m_rdata = rdata_val;

    // monitor: grant log, ready pulse counts and cycle stamps
    logic [31:0] grant_log[$];
    logic [31:0] exp_q[$];
    int          i_rdy_n = 0;
    int          d_rdy_n = 0;
    int          i_rdy_cyc = 0;
    int          d_rdy_cyc = 0;
    logic        prev_req = 1'b0;

    always @(negedge clk) begin
        if (m_req && !prev_req) grant_log.push_back(m_addr);
        prev_req = m_req;
        if (i_ready || d_ready) check("ready_excl", 32'(i_ready & d_ready), 32'd0);
        if (i_ready) begin
            i_rdy_n++;
            i_rdy_cyc = cyc;
        end
        if (d_ready) begin
            d_rdy_n++;
            d_rdy_cyc = cyc;
        end
    end

    // driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input logic is_i, input string tag);
        int   n = 0;
        logic seen;
        do begin
            @(negedge clk);
            n++;
            seen = is_i ? i_ready : d_ready;
        end while (!seen && n < 60);
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, 32'(grant_log.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < grant_log.size(); k++) begin
            check($sformatf("%s_%0d", tag, k), grant_log[k], exp_q[k]);
        end
        grant_log.delete();
        exp_q.delete();
    endtask

    initial begin
        // 1: outputs held at zero in reset, idle after release
        i_req = 1'b1; i_addr = $urandom; d_req = 1'b1; d_we = 1'b1;
        d_addr = $urandom; d_wdata = $urandom; force_ack = 1'b1; rdata_val = $urandom;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_req",   32'(m_req), 32'd0);
        check("rst_m_we",    32'(m_we), 32'd0);
        check("rst_m_addr",  m_addr, 32'd0);
        check("rst_m_wdata", m_wdata, 32'd0);
        check("rst_i_ready", 32'(i_ready), 32'd0);
        check("rst_d_ready", 32'(d_ready), 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; force_ack = 1'b0;
        next_cycle();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_m_req", 32'(m_req), 32'd0);
        check("idle_busy",  32'(busy), 32'd0);
        check("idle_state", 32'(o_state), 32'd0);
        grant_log.delete();

        // 2: single fetch, ack in the third grant cycle
        next_cycle();
        ack_delay = 2; rdata_val = 32'hDEADBEEF;
        i_addr = 32'h40; i_req = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("f_m_req_c%0d", c), 32'(m_req), 32'((c >= 1) && (c <= 3)));
            check($sformatf("f_i_ready_c%0d", c), 32'(i_ready), 32'(c == 4));
            if (m_req) begin
                check("f_m_addr", m_addr, 32'h40);
                check("f_m_we", 32'(m_we), 32'd0);
            end
            if (c == 4) begin
                check("f_i_rdata", i_rdata, 32'hDEADBEEF);
                next_cycle();
                i_req = 1'b0;
            end
        end
        exp_q.push_back(32'h40);
        check_log("f_grant");

        // 3: simultaneous requests, immediate ack: data first, fetch 3 cycles later
        next_cycle();
        ack_delay = 0; rdata_val = 32'h11110000;
        d_we = 1'b0; d_addr = 32'h100; d_req = 1'b1;
        i_addr = 32'h44; i_req = 1'b1;
        fork
            begin
                wait_rdy(1'b0, "both_d_ready");
                next_cycle();
                d_req = 1'b0;
            end
            begin
                wait_rdy(1'b1, "both_i_ready");
                next_cycle();
                i_req = 1'b0;
            end
        join
        check("both_gap", 32'(i_rdy_cyc - d_rdy_cyc), 32'd3);
        check("both_d_rdata", d_rdata, 32'h11110000);
        check("both_i_rdata", i_rdata, 32'h11110000);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h44);
        check_log("both_grant");

        // 4: starvation limit 2 with both sides continuously requesting
        next_cycle();
        rdata_val = 32'hCAFE0004;
        d_addr = 32'h300; d_req = 1'b1;
        i_addr = 32'h84; i_req = 1'b1;
        fork
            begin
                repeat (4) wait_rdy(1'b0, "starve_d_ready");
                next_cycle();
                d_req = 1'b0;
            end
            begin
                repeat (2) wait_rdy(1'b1, "starve_i_ready");
                next_cycle();
                i_req = 1'b0;
            end
        join
        exp_q = '{32'h300, 32'h300, 32'h84, 32'h300, 32'h300, 32'h84};
        check_log("starve_grant");

        // 5: store keeps the previous load data
        next_cycle();
        ack_delay = 1; rdata_val = 32'hBAD0BAD0;
        d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678; d_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("st_m_req",   32'(m_req), 32'd1);
        check("st_m_we",    32'(m_we), 32'd1);
        check("st_m_addr",  m_addr, 32'h200);
        check("st_m_wdata", m_wdata, 32'h12345678);
        wait_rdy(1'b0, "st_d_ready");
        check("st_d_rdata", d_rdata, 32'hCAFE0004);
        next_cycle();
        d_req = 1'b0; d_we = 1'b0;
        grant_log.delete();

        // 6: reset during a data grant, then fetch, then a stray ack in idle
        next_cycle();
        ack_delay = 10;
        d_addr = 32'h180; d_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ab_m_req_before", 32'(m_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("ab_m_req",   32'(m_req), 32'd0);
        check("ab_busy",    32'(busy), 32'd0);
        check("ab_d_rdata", d_rdata, 32'd0);
        d_req = 1'b0;
        next_cycle();
        reset = 1'b1;
        grant_log.delete();
        next_cycle();
        ack_delay = 0; rdata_val = 32'h0BADF00D;
        i_addr = 32'h48; i_req = 1'b1;
        wait_rdy(1'b1, "ab_i_ready");
        check("ab_i_rdata", i_rdata, 32'h0BADF00D);
        next_cycle();
        i_req = 1'b0;
        exp_q.push_back(32'h48);
        check_log("ab_grant");
        begin
            int i_before;
            int d_before;
            i_before = i_rdy_n;
            d_before = d_rdy_n;
            next_cycle();
            next_cycle();
            force_ack = 1'b1; rdata_val = 32'h77777777;
            next_cycle();
            force_ack = 1'b0;
            repeat (3) @(negedge clk);
            check("sp_i_ready_n", 32'(i_rdy_n), 32'(i_before));
            check("sp_d_ready_n", 32'(d_rdy_n), 32'(d_before));
            check("sp_i_rdata", i_rdata, 32'h0BADF00D);
            check("sp_d_rdata", d_rdata, 32'd0);
            check("sp_busy", 32'(busy), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
